rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
//  Consumer (pop) side of the superscalar ROB circular queue. Each cycle it inspects the
//  SUPERSCALAR oldest queue entries and retires the longest in-order prefix that is
//  ready. It drives pop/amount back to the queue and registered commit writes to the
//  RRF/free list. On a retired mispredict it runs the flush/redirect sequence.
// PARAMETERS
//  SUPERSCALAR   4   retire width; slot 0 = oldest entry
//  SS_BITS       2   log2(SUPERSCALAR)
//  DEPTH_BITS    4   log2(queue depth)
//  ARCH_BITS     5   architectural register index width
//  PHYS_BITS     6   physical register index width
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 synchronous reset, active-low (asserted when 0)
//  occupancy        in   DEPTH_BITS+1      valid entries in queue (0..2^DEPTH_BITS)
//  slot_ready       in   SUPERSCALAR       entry i has completed execution
//  slot_mispredict  in   SUPERSCALAR       entry i is a resolved mispredicted branch
//  slot_has_rd      in   SUPERSCALAR       entry i writes a destination register
//  slot_rd_arch     in   ARCH_BITS x SS    entry i arch dest
//  slot_rd_phys     in   PHYS_BITS x SS    entry i phys dest
//  slot_target_pc   in   32 x SS           entry i correct next PC
//  commit_stall     in   1                 RRF/free list busy; no retirement this cycle
//  flush_done       in   1                 frontend/backend flush complete
//  pop              out  1                 queue dequeue strobe (combinational)
//  amount           out  SS_BITS+1         entries to dequeue, 0..SUPERSCALAR (combinational)
//  commit_valid     out  SUPERSCALAR       registered: slot i retired with a dest write
//  commit_rd_arch   out  ARCH_BITS x SS    registered arch dest per slot
//  commit_rd_phys   out  PHYS_BITS x SS    registered phys dest per slot
//  flush            out  1                 one-cycle pipeline flush pulse
//  redirect_pc      out  32                fetch redirect target, valid with flush
//  retired_count    out  32                total retired instructions, wraps at 2^32
// BEHAVIOUR
//  States: RUN, FLUSH, WAIT. Reset (rst==0 at posedge) -> RUN, all outputs 0, counter 0.
//  RUN, retire count k: slot i is eligible iff i < occupancy and slot_ready[i].
//   k = number of leading eligible slots. If a slot j < k has slot_mispredict, the
//   lowest such j sets k = j+1. commit_stall=1 forces k=0.
//   pop = (k!=0), amount = k, same cycle. amount is SS_BITS+1 wide; the queue's amount
//   port is widened to match.
//  Next edge: commit_valid[i] = (i<k) & slot_has_rd[i], rd fields latched for all i;
//   slots i>=k and non-RUN states give commit_valid 0. retired_count += k.
//  Mispredict retired at j: next state FLUSH; redirect_pc <= slot_target_pc[j].
//  FLUSH: flush=1 for exactly one cycle, pop=0, then WAIT. redirect_pc held.
//  WAIT: pop=0, flush=0; on flush_done=1 -> RUN (first retirement on the next cycle).
//   flush_done in RUN/FLUSH is ignored.
//  occupancy==0 -> k=0. occupancy>=SUPERSCALAR -> all slots considered.
//  slot data for i>=occupancy is don't-care; it must not affect any output.
//  Reset mid-FLUSH/WAIT -> RUN immediately, flush deasserts, no redirect.
//  Queue wrap-around is invisible here; slots are always presented oldest-first.
// TESTING
//  occ=4, ready=1111, no mispredict -> pop=1, amount=4; next cycle commit_valid=has_rd; count+=4
//  occ=4, ready=1101 (slot1 not ready) -> amount=1; only slot0 committed
//  occ=2, ready=1111 -> amount=2; slots 2,3 ignored even with mispredict set there
//  occ=4, ready=1111, mispredict=0100 (slot2) -> amount=3; flush pulse 1 cycle later,
//   redirect_pc=slot_target_pc[2]; pop=0 until flush_done, then RUN
//  commit_stall=1 with occ=4 all ready -> pop=0, amount=0, commit_valid=0, count unchanged
//  rst=0 during WAIT -> next cycle state RUN, flush=0, outputs zero, retired_count=0

Source files
------------

// File: rtl/rob_retire.sv
// ----------------------------------------------------------------------------
// rob_retire
//   Retire (pop) side of the reorder buffer. Every cycle the SUPERSCALAR oldest
//   entries are inspected and the longest in-order prefix of completed entries
//   is retired, stopping just after the first retired mispredicted branch.
//   The dequeue request (pop/amount) goes back to the queue combinationally.
//   The commit writes to the RRF/free list are registered. Retiring a
//   mispredict starts the FLUSH -> WAIT -> RUN sequence, which drives a
//   one-cycle flush pulse and a held redirect PC.
//
// Handshake: pop/amount is a strobe, not a valid/ready pair. The queue must
//   dequeue exactly 'amount' entries in any cycle with pop=1. commit_stall
//   acts as the only back-pressure and holds retirement at zero for that
//   cycle.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   occupancy         number of valid entries in the queue (0..2^DEPTH_BITS)
//   slot_*            per-slot status/data, slot 0 is the oldest entry;
//                     slot i occupies bits [i*W +: W] of each flat vector
//   commit_stall      RRF/free list busy, retire nothing this cycle
//   flush_done        flush complete, honoured only in WAIT
//   pop, amount       dequeue strobe and count (combinational)
//   commit_*          registered per-slot register commit
//   flush             one-cycle flush pulse
//   redirect_pc       fetch redirect target, valid with flush and held after
//   retired_count     running total of retired instructions (wraps)
//   o_dbg_state       current FSM state (0 RUN, 1 FLUSH, 2 WAIT)
// ----------------------------------------------------------------------------
module rob_retire #(
    parameter int SUPERSCALAR = 4,
    parameter int SS_BITS     = 2,
    parameter int DEPTH_BITS  = 4,
    parameter int ARCH_BITS   = 5,
    parameter int PHYS_BITS   = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DEPTH_BITS:0]              occupancy,
    input  logic [SUPERSCALAR-1:0]           slot_ready,
    input  logic [SUPERSCALAR-1:0]           slot_mispredict,
    input  logic [SUPERSCALAR-1:0]           slot_has_rd,
    input  logic [SUPERSCALAR*ARCH_BITS-1:0] slot_rd_arch,
    input  logic [SUPERSCALAR*PHYS_BITS-1:0] slot_rd_phys,
    input  logic [SUPERSCALAR*32-1:0]        slot_target_pc,
    input  logic                             commit_stall,
    input  logic                             flush_done,
    output logic                             pop,
    output logic [SS_BITS:0]                 amount,
    output logic [SUPERSCALAR-1:0]           commit_valid,
    output logic [SUPERSCALAR*ARCH_BITS-1:0] commit_rd_arch,
    output logic [SUPERSCALAR*PHYS_BITS-1:0] commit_rd_phys,
    output logic                             flush,
    output logic [31:0]                      redirect_pc,
    output logic [31:0]                      retired_count,
    output logic [1:0]                       o_dbg_state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_state_next;

    logic [SUPERSCALAR-1:0]           r_commit_valid;
    logic [SUPERSCALAR*ARCH_BITS-1:0] r_commit_rd_arch;
    logic [SUPERSCALAR*PHYS_BITS-1:0] r_commit_rd_phys;
    logic [31:0]                      r_redirect_pc;
    logic [31:0]                      r_retired_count;

    logic [SUPERSCALAR-1:0]           w_in_queue;
    logic [SUPERSCALAR-1:0]           w_eligible;
    logic                             w_stop;
    logic                             w_retire_en;
    logic [SS_BITS:0]                 w_k;
    logic                             w_mp_hit;
    logic [31:0]                      w_mp_pc;
    logic [SUPERSCALAR-1:0]           w_commit_valid_nxt;
    logic [SUPERSCALAR*ARCH_BITS-1:0] w_rd_arch_nxt;
    logic [SUPERSCALAR*PHYS_BITS-1:0] w_rd_phys_nxt;

    // ------------------------------------------------------------------
    // Retire-count selection. Walk the slots oldest-first. Stop at the
    // first slot that is not eligible, or just after the first eligible
    // mispredict, because nothing younger than a wrong-path branch may
    // retire. Slots beyond occupancy are masked off before they can
    // influence anything.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_queue = '0;
        w_eligible = '0;
        w_stop     = 1'b0;
        w_k        = '0;
        w_mp_hit   = 1'b0;
        w_mp_pc    = '0;

        for (int i = 0; i < SUPERSCALAR; i++) begin
            w_in_queue[i] = (int'(occupancy) > i);
            w_eligible[i] = w_in_queue[i] && slot_ready[i];
        end

        for (int i = 0; i < SUPERSCALAR; i++) begin
            if (!w_stop) begin
                if (w_eligible[i]) begin
                    w_k = (SS_BITS+1)'(i + 1);
                    if (slot_mispredict[i]) begin
                        w_mp_hit = 1'b1;
                        w_mp_pc  = slot_target_pc[i*32 +: 32];
                        w_stop   = 1'b1;
                    end
                end else begin
                    w_stop = 1'b1;
                end
            end
        end

        // Retirement only happens in RUN, out of reset, with the commit
        // path free. Otherwise the whole selection collapses to zero.
        w_retire_en = rst && (r_state == S_RUN) && !commit_stall;
        if (!w_retire_en) begin
            w_k      = '0;
            w_mp_hit = 1'b0;
        end

        // Destination fields of slots outside the queue are zeroed so
        // that stale slot data never reaches the commit outputs.
        w_commit_valid_nxt = '0;
        w_rd_arch_nxt      = '0;
        w_rd_phys_nxt      = '0;
        for (int i = 0; i < SUPERSCALAR; i++) begin
            w_commit_valid_nxt[i] = (int'(w_k) > i) && slot_has_rd[i];
            if (w_in_queue[i]) begin
                w_rd_arch_nxt[i*ARCH_BITS +: ARCH_BITS] = slot_rd_arch[i*ARCH_BITS +: ARCH_BITS];
                w_rd_phys_nxt[i*PHYS_BITS +: PHYS_BITS] = slot_rd_phys[i*PHYS_BITS +: PHYS_BITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. flush_done only matters while waiting in WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (w_mp_hit) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (flush_done) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered commit outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_RUN;
            r_commit_valid   <= '0;
            r_commit_rd_arch <= '0;
            r_commit_rd_phys <= '0;
            r_redirect_pc    <= '0;
            r_retired_count  <= '0;
        end else begin
            r_state          <= w_state_next;
            r_commit_valid   <= w_commit_valid_nxt;
            r_commit_rd_arch <= w_rd_arch_nxt;
            r_commit_rd_phys <= w_rd_phys_nxt;
            r_retired_count  <= r_retired_count + 32'(w_k);
            // The redirect target is captured with the mispredict and then
            // held through FLUSH and WAIT.
            if (w_mp_hit) begin
                r_redirect_pc <= w_mp_pc;
            end
        end
    end

    assign pop            = (w_k != '0);
    assign amount         = w_k;
    assign commit_valid   = r_commit_valid;
    assign commit_rd_arch = r_commit_rd_arch;
    assign commit_rd_phys = r_commit_rd_phys;
    assign flush          = (r_state == S_FLUSH);
    assign redirect_pc    = r_redirect_pc;
    assign retired_count  = r_retired_count;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;

    localparam int SS  = 4;
    localparam int SSB = 2;
    localparam int DB  = 4;
    localparam int AB  = 5;
    localparam int PB  = 6;
    localparam int W   = SS + SS*AB + SS*PB + 32;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic              clk;
    logic              rst;
    logic [DB:0]       occupancy;
    logic [SS-1:0]     slot_ready;
    logic [SS-1:0]     slot_mispredict;
    logic [SS-1:0]     slot_has_rd;
    logic [SS*AB-1:0]  slot_rd_arch;
    logic [SS*PB-1:0]  slot_rd_phys;
    logic [SS*32-1:0]  slot_target_pc;
    logic              commit_stall;
    logic              flush_done;
    logic              pop;
    logic [SSB:0]      amount;
    logic [SS-1:0]     commit_valid;
    logic [SS*AB-1:0]  commit_rd_arch;
    logic [SS*PB-1:0]  commit_rd_phys;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic [31:0]       retired_count;
    logic [1:0]        o_dbg_state;

    int                n_checks;
    int                n_fail;
    logic [31:0]       model_count;
    logic [W-1:0]      exp_q[$];

    rob_retire #(
        .SUPERSCALAR(SS), .SS_BITS(SSB), .DEPTH_BITS(DB), .ARCH_BITS(AB), .PHYS_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst), .occupancy(occupancy),
        .slot_ready(slot_ready), .slot_mispredict(slot_mispredict),
        .slot_has_rd(slot_has_rd), .slot_rd_arch(slot_rd_arch),
        .slot_rd_phys(slot_rd_phys), .slot_target_pc(slot_target_pc),
        .commit_stall(commit_stall), .flush_done(flush_done),
        .pop(pop), .amount(amount), .commit_valid(commit_valid),
        .commit_rd_arch(commit_rd_arch), .commit_rd_phys(commit_rd_phys),
        .flush(flush), .redirect_pc(redirect_pc), .retired_count(retired_count),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic rand_slots();
        slot_has_rd = 4'($urandom_range(0, 15));
        for (int i = 0; i < SS; i++) begin
            slot_rd_arch[i*AB +: AB]   = 5'($urandom_range(0, 31));
            slot_rd_phys[i*PB +: PB]   = 6'($urandom_range(0, 63));
            slot_target_pc[i*32 +: 32] = $urandom();
        end
    endtask

    task automatic drive(input logic [DB:0] occ, input logic [SS-1:0] rdy,
                         input logic [SS-1:0] mp, input logic st);
        occupancy       = occ;
        slot_ready      = rdy;
        slot_mispredict = mp;
        commit_stall    = st;
    endtask

    // Reference retire count: leading ready run within occupancy, then cut
    // back to end at the oldest mispredict inside that run.
    function automatic int model_k(output int mp_idx);
        int k;
        k = 0;
        mp_idx = -1;
        if (commit_stall) return 0;
        while (k < SS && k < int'(occupancy) && slot_ready[k]) k++;
        for (int j = 0; j < k; j++) begin
            if (slot_mispredict[j]) begin
                mp_idx = j;
                k = j + 1;
                break;
            end
        end
        return k;
    endfunction

    function automatic logic [W-1:0] make_pkt(input int k, input logic [31:0] cnt);
        logic [SS-1:0]    cv;
        logic [SS*AB-1:0] a;
        logic [SS*PB-1:0] p;
        cv = '0; a = '0; p = '0;
        for (int i = 0; i < SS; i++) begin
            if (i < k && slot_has_rd[i]) begin
                cv[i]          = 1'b1;
                a[i*AB +: AB]  = slot_rd_arch[i*AB +: AB];
                p[i*PB +: PB]  = slot_rd_phys[i*PB +: PB];
            end
        end
        return {cv, a, p, cnt};
    endfunction

    function automatic logic [W-1:0] obs_pkt();
        logic [SS*AB-1:0] a;
        logic [SS*PB-1:0] p;
        a = '0; p = '0;
        for (int i = 0; i < SS; i++) begin
            if (commit_valid[i]) begin
                a[i*AB +: AB] = commit_rd_arch[i*AB +: AB];
                p[i*PB +: PB] = commit_rd_phys[i*PB +: PB];
            end
        end
        return {commit_valid, a, p, retired_count};
    endfunction

    // Push the expected commit for the currently driven cycle.
    task automatic push_expected(input int k);
        model_count = model_count + 32'(k);
        exp_q.push_back(make_pkt(k, model_count));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive('0, '0, '0, 1'b0);
        flush_done = 1'b0;
        rand_slots();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (commit_valid !== '0) begin n_fail++; $display("FAIL reset_commit_valid got=%b exp=0", commit_valid); end
        n_checks++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
        n_checks++; if (o_dbg_state !== ST_RUN) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, ST_RUN); end
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b exp=0", pop); end
        rst = 1'b1;
        model_count = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_retire();
        logic [W-1:0] e;
        rand_slots();
        drive(5'd4, 4'b1111, 4'b0000, 1'b0);
        #1;
        n_checks++; if (pop !== 1'b1) begin n_fail++; $display("FAIL full_pop got=%b exp=1", pop); end
        n_checks++; if (amount !== 3'd4) begin n_fail++; $display("FAIL full_amount got=%0d exp=4", amount); end
        push_expected(4);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL full_commit got=%h exp=%h", obs_pkt(), e); end
    endtask

    task automatic test_partial_ready();
        logic [W-1:0] e;
        rand_slots();
        drive(5'd4, 4'b1101, 4'b0000, 1'b0);
        #1;
        n_checks++; if (amount !== 3'd1 || pop !== 1'b1) begin n_fail++; $display("FAIL partial_amount got=%0d/%b exp=1/1", amount, pop); end
        push_expected(1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL partial_commit got=%h exp=%h", obs_pkt(), e); end
    endtask

    task automatic test_occ_limit();
        logic [W-1:0] e;
        rand_slots();
        drive(5'd2, 4'b1111, 4'b1100, 1'b0);
        #1;
        n_checks++; if (amount !== 3'd2) begin n_fail++; $display("FAIL occ2_amount got=%0d exp=2", amount); end
        push_expected(2);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL occ2_commit got=%h exp=%h", obs_pkt(), e); end
        n_checks++; if (o_dbg_state !== ST_RUN || flush !== 1'b0) begin n_fail++; $display("FAIL occ2_no_flush got=%0d/%b exp=0/0", o_dbg_state, flush); end
        rand_slots();
        drive(5'd0, 4'b1111, 4'b1111, 1'b0);
        #1;
        n_checks++; if (pop !== 1'b0 || amount !== 3'd0) begin n_fail++; $display("FAIL occ0_pop got=%b/%0d exp=0/0", pop, amount); end
        push_expected(0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL occ0_commit got=%h exp=%h", obs_pkt(), e); end
        n_checks++; if (o_dbg_state !== ST_RUN) begin n_fail++; $display("FAIL occ0_state got=%0d exp=0", o_dbg_state); end
    endtask

    task automatic test_stall();
        logic [W-1:0] e;
        rand_slots();
        slot_has_rd = 4'b1111;
        drive(5'd4, 4'b1111, 4'b0000, 1'b1);
        #1;
        n_checks++; if (pop !== 1'b0 || amount !== 3'd0) begin n_fail++; $display("FAIL stall_pop got=%b/%0d exp=0/0", pop, amount); end
        push_expected(0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL stall_commit got=%h exp=%h", obs_pkt(), e); end
        commit_stall = 1'b0;
    endtask

    task automatic test_mispredict();
        logic [W-1:0] e;
        logic [31:0]  tgt;
        rand_slots();
        drive(5'd4, 4'b1111, 4'b0100, 1'b0);
        tgt = slot_target_pc[2*32 +: 32];
        #1;
        n_checks++; if (amount !== 3'd3 || pop !== 1'b1) begin n_fail++; $display("FAIL mp_amount got=%0d/%b exp=3/1", amount, pop); end
        push_expected(3);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL mp_commit got=%h exp=%h", obs_pkt(), e); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mp_flush got=%b exp=1", flush); end
        n_checks++; if (redirect_pc !== tgt) begin n_fail++; $display("FAIL mp_redirect got=%h exp=%h", redirect_pc, tgt); end
        // FLUSH cycle: flush_done here must be ignored
        rand_slots();
        drive(5'd4, 4'b1111, 4'b0000, 1'b0);
        flush_done = 1'b1;
        #1;
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL flush_pop got=%b exp=0", pop); end
        push_expected(0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL flush_commit got=%h exp=%h", obs_pkt(), e); end
        n_checks++; if (flush !== 1'b0 || o_dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL flush_one_cycle got=%b/%0d exp=0/2", flush, o_dbg_state); end
        flush_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_slots();
            #1;
            n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL wait_pop got=%b exp=0 cyc=%0d", pop, c); end
            push_expected(0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL wait_commit got=%h exp=%h", obs_pkt(), e); end
            n_checks++; if (flush !== 1'b0 || redirect_pc !== tgt) begin n_fail++; $display("FAIL wait_hold got=%b/%h exp=0/%h", flush, redirect_pc, tgt); end
        end
        flush_done = 1'b1;
        #1;
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL wait_done_pop got=%b exp=0", pop); end
        push_expected(0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL wait_done_commit got=%h exp=%h", obs_pkt(), e); end
        n_checks++; if (o_dbg_state !== ST_RUN) begin n_fail++; $display("FAIL wait_exit got=%0d exp=0", o_dbg_state); end
        flush_done = 1'b0;
        rand_slots();
        #1;
        n_checks++; if (pop !== 1'b1 || amount !== 3'd4) begin n_fail++; $display("FAIL resume_amount got=%b/%0d exp=1/4", pop, amount); end
        push_expected(4);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL resume_commit got=%h exp=%h", obs_pkt(), e); end
        n_checks++; if (redirect_pc !== tgt) begin n_fail++; $display("FAIL resume_redirect got=%h exp=%h", redirect_pc, tgt); end
    endtask

    task automatic test_reset_in_wait();
        rand_slots();
        drive(5'd1, 4'b0001, 4'b0001, 1'b0);
        @(posedge clk); #1;
        drive(5'd0, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk); #1;
        n_checks++; if (o_dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rw_reach_wait got=%0d exp=2", o_dbg_state); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_count = '0;
        exp_q.delete();
        n_checks++; if (o_dbg_state !== ST_RUN) begin n_fail++; $display("FAIL rw_state got=%0d exp=0", o_dbg_state); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rw_flush got=%b exp=0", flush); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_fail++; $display("FAIL rw_redirect got=%h exp=0", redirect_pc); end
        n_checks++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL rw_count got=%0d exp=0", retired_count); end
        n_checks++; if (commit_valid !== '0) begin n_fail++; $display("FAIL rw_commit got=%b exp=0", commit_valid); end
    endtask

    task automatic test_random();
        logic [1:0]   m_state;
        logic [31:0]  m_redirect;
        logic [W-1:0] e;
        int           k;
        int           mi;
        m_state    = ST_RUN;
        m_redirect = 32'd0;
        for (int c = 0; c < 60; c++) begin
            rand_slots();
            drive(5'($urandom_range(0, 16)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                  ($urandom_range(0, 7) == 0));
            flush_done = ($urandom_range(0, 2) == 0);
            k = model_k(mi);
            if (m_state != ST_RUN) begin
                k  = 0;
                mi = -1;
            end
            #1;
            n_checks++; if (pop !== (k != 0) || amount !== 3'(k)) begin n_fail++; $display("FAIL rnd_amount cyc=%0d got=%b/%0d exp=%b/%0d", c, pop, amount, k != 0, k); end
            push_expected(k);
            case (m_state)
                ST_RUN: if (mi >= 0) begin m_state = ST_FLUSH; m_redirect = slot_target_pc[mi*32 +: 32]; end
                ST_FLUSH: m_state = ST_WAIT;
                default: if (flush_done) m_state = ST_RUN;
            endcase
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++; if (obs_pkt() !== e) begin n_fail++; $display("FAIL rnd_commit cyc=%0d got=%h exp=%h", c, obs_pkt(), e); end
            n_checks++; if (flush !== (m_state == ST_FLUSH) || redirect_pc !== m_redirect) begin n_fail++; $display("FAIL rnd_flush cyc=%0d got=%b/%h exp=%b/%h", c, flush, redirect_pc, m_state == ST_FLUSH, m_redirect); end
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_count = '0;
        rst         = 1'b0;
        flush_done  = 1'b0;
        drive('0, '0, '0, 1'b0);
        slot_has_rd    = '0;
        slot_rd_arch   = '0;
        slot_rd_phys   = '0;
        slot_target_pc = '0;
        test_reset();
        test_full_retire();
        test_partial_ready();
        test_occ_limit();
        test_stall();
        test_mispredict();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
